beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Downstream consumer of the beat generator's `pulse` output.
- Tracks the beat position within a bar (1–8 beats per bar) and flags downbeats.
- Drives a one-hot beat LED bank.
- Emits a fixed-length square-wave click per beat, at a higher pitch on the accented downbeat. The click feeds the board's piezo/audio pin.

Parameters:
- CLICK_LEN, 20, click duration in clk cycles (>= 2).
- ACC_HALF, 2, tone half-period in cycles for the accented (downbeat) click.
- NORM_HALF, 4, tone half-period in cycles for the normal click.
- CW, 8, width of the click-length and half-period counters; must hold max(CLICK_LEN, NORM_HALF).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pulse  in  1  beat strobe from beat generator; may stay high several cycles while that block is held in reset
- enable  in  1  sync; 0 mutes and freezes the sequencer
- bar_restart  in  1  sync; forces the next beat to be the downbeat (tie to the tempo-change force_reset)
- beats_per_bar  in  3  beats per bar; 0 encodes 8, 1..7 literal
- beat_idx  out  3  index of the most recently sounded beat (0 = downbeat)
- downbeat  out  1  one-cycle strobe, registered, on detection of beat 0
- led  out  8  one-hot of beat_idx; 0 until the first beat after reset
- click_active  out  1  high while a click is sounding
- tone  out  1  click square wave; 0 when idle

Behaviour:
- Async reset, all registers cleared:
  - state IDLE
  - beat_idx 0, next_idx 0, started 0
  - downbeat 0, led 0, click_active 0, tone 0
  - pulse_d 0, both counters 0
- Edge detect:
  - pulse_d <= pulse every cycle.
  - beat_evt = pulse & ~pulse_d & enable.
  - A pulse held high N cycles yields exactly one beat_evt.
- On beat_evt (edge E), effects visible after E:
  - beat_idx <= next_idx; started <= 1.
  - downbeat <= (next_idx == 0) for one cycle.
  - accent <= (next_idx == 0).
  - next_idx <= 0 if next_idx+1 >= BPB, else next_idx+1. BPB = 8 when beats_per_bar == 0.
- A change to beats_per_bar takes effect at the next beat_evt via the wrap compare. If next_idx is already >= the new BPB, it wraps to 0.
- bar_restart: next_idx <= 0 and beat_idx is unchanged. It wins over the next_idx update of a simultaneous beat_evt. That beat still sounds using the old next_idx.
- led = started ? (8'b1 << beat_idx) : 8'b0, registered.
- FSM states: IDLE, CLICK.
  - IDLE -> CLICK on beat_evt: len_cnt <= CLICK_LEN-1, half_cnt <= HALF-1, tone <= 1, click_active <= 1. HALF = ACC_HALF if accent else NORM_HALF.
  - CLICK, each cycle:
    - If half_cnt == 0: tone toggles and half_cnt reloads HALF-1; otherwise half_cnt decrements.
    - If len_cnt == 0: go to IDLE, tone <= 0, click_active <= 0; otherwise len_cnt decrements.
  - click_active is therefore high for exactly CLICK_LEN cycles.
  - CLICK -> CLICK on beat_evt (retrigger): reload as on entry with the new accent; the old click is truncated.
  - Any state, enable == 0: go to IDLE, tone 0, click_active 0 on the next edge. beat_idx, next_idx and led hold.
- Latency: pulse rising at edge E, then tone, click_active, downbeat and beat_idx all change at E+1.
- Reset asserted mid-click: tone and click_active drop immediately (async).

Decomposition:
- Shared package `beat_pkg`:
  - state enum {IDLE, CLICK}.
  - BPB decode constant (3'b000 => 8).
  - Default CLICK_LEN / ACC_HALF / NORM_HALF.
- One natural sub-module, `click_tone_gen`:
  - Holds the FSM plus both counters.
  - Inputs: trigger, accent, enable. Outputs: tone, click_active.
- Bar/position logic and the edge detect stay in beat_sequencer.

Test Plan:
- Reset, beats_per_bar=4, enable=1, 1-cycle pulses every 50 cycles -> beat_idx 0,1,2,3,0; downbeat high on beats 1 and 5 only; led 01,02,04,08,01; tone toggles every 2 cycles on downbeats and every 4 otherwise; click_active high exactly 20 cycles per beat.
- pulse held high 5 cycles -> exactly one beat_evt; beat_idx advances by 1; single 20-cycle click.
- Pulse during an active click at cycle 10 -> click retriggers; click_active stays high a total of 10+20=30 cycles; tone restarts at 1 with the new beat's half-period.
- beats_per_bar=0 -> indices 0..7 then wrap to 0; led reaches 8'h80. Switch to 3 when next_idx=5 -> next beat is idx 5, the following one is idx 0.
- bar_restart asserted with next_idx=2 -> next beat_idx 0 with downbeat=1 and accented tone; simultaneous with a beat_evt -> that beat is idx 2, the following one idx 0.
- enable dropped mid-click -> tone and click_active are 0 on the next edge; pulses while disabled are ignored and beat_idx holds. Async reset mid-click -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared types, defaults and bar helpers for the beat sequencer
package beat_pkg;

    // Click generator states
    typedef enum logic {
        IDLE  = 1'b0,
        CLICK = 1'b1
    } click_state_e;

    // Default click shape
    localparam int DEF_CLICK_LEN = 20;
    localparam int DEF_ACC_HALF  = 2;
    localparam int DEF_NORM_HALF = 4;
    localparam int DEF_CW        = 8;

    // beats_per_bar encoding that stands for a full bar of eight beats
    localparam logic [2:0] BPB_ENC_EIGHT = 3'b000;

    // Decode the 3-bit beats_per_bar field into a beat count of 1..8
    function automatic logic [3:0] bpb_decode(input logic [2:0] enc);
        logic [3:0] cnt;
        if (enc == BPB_ENC_EIGHT) begin
            cnt = 4'd8;
        end else begin
            cnt = {1'b0, enc};
        end
        return cnt;
    endfunction

    // Position after idx; a shrunk bar (idx already past the end) also wraps to 0
    function automatic logic [2:0] wrap_next(input logic [2:0] idx, input logic [2:0] enc);
        logic [3:0] inc;
        logic [2:0] nxt;
        inc = {1'b0, idx} + 4'd1;
        if (inc >= bpb_decode(enc)) begin
            nxt = 3'd0;
        end else begin
            nxt = inc[2:0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/click_tone_gen.sv
// rtl/click_tone_gen.sv - fixed-length square-wave click, pitch chosen per trigger
module click_tone_gen
    import beat_pkg::*;
#(
    parameter int CLICK_LEN = DEF_CLICK_LEN,
    parameter int ACC_HALF  = DEF_ACC_HALF,
    parameter int NORM_HALF = DEF_NORM_HALF,
    parameter int CW        = DEF_CW
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic trigger,
    input  logic accent,
    output logic tone,
    output logic click_active
);

    localparam logic [CW-1:0] LEN_LOAD  = CW'(CLICK_LEN - 1);
    localparam logic [CW-1:0] ACC_LOAD  = CW'(ACC_HALF - 1);
    localparam logic [CW-1:0] NORM_LOAD = CW'(NORM_HALF - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    click_state_e  state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] half_q, half_d;
    logic          acc_q, acc_d;
    logic          tone_q, tone_d;
    logic          active_q, active_d;

    // State and counter registers, cleared asynchronously so the pin goes quiet at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            half_q   <= '0;
            acc_q    <= 1'b0;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            half_q   <= half_d;
            acc_q    <= acc_d;
            tone_q   <= tone_d;
            active_q <= active_d;
        end
    end

    // Next state: mute beats retrigger, retrigger beats the running click
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        half_d   = half_q;
        acc_d    = acc_q;
        tone_d   = tone_q;
        active_d = active_q;

        if (!enable) begin
            state_d  = IDLE;
            len_d    = '0;
            half_d   = '0;
            tone_d   = 1'b0;
            active_d = 1'b0;
        end else if (trigger) begin
            // Entry and retrigger share one path: restart the click from its first half-period
            state_d  = CLICK;
            len_d    = LEN_LOAD;
            acc_d    = accent;
            half_d   = accent ? ACC_LOAD : NORM_LOAD;
            tone_d   = 1'b1;
            active_d = 1'b1;
        end else if (state_q == CLICK) begin
            if (half_q == '0) begin
                tone_d = ~tone_q;
                half_d = acc_q ? ACC_LOAD : NORM_LOAD;
            end else begin
                half_d = half_q - ONE;
            end
            // End of click overrides any toggle so the pin rests low
            if (len_q == '0) begin
                state_d  = IDLE;
                tone_d   = 1'b0;
                active_d = 1'b0;
            end else begin
                len_d = len_q - ONE;
            end
        end
    end

    assign tone         = tone_q;
    assign click_active = active_q;

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - bar position tracking, beat LEDs and per-beat click
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int CLICK_LEN = DEF_CLICK_LEN,
    parameter int ACC_HALF  = DEF_ACC_HALF,
    parameter int NORM_HALF = DEF_NORM_HALF,
    parameter int CW        = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse,
    input  logic       enable,
    input  logic       bar_restart,
    input  logic [2:0] beats_per_bar,
    output logic [2:0] beat_idx,
    output logic       downbeat,
    output logic [7:0] led,
    output logic       click_active,
    output logic       tone
);

    logic       pulse_dly_q, pulse_dly_d;
    logic [2:0] beat_idx_q, beat_idx_d;
    logic [2:0] next_idx_q, next_idx_d;
    logic       started_q, started_d;
    logic       downbeat_q, downbeat_d;
    logic [7:0] led_q, led_d;

    logic beat_evt;
    logic accent_now;

    // Rising edge only, so a pulse held high by a stalled generator counts once
    assign beat_evt   = pulse & ~pulse_dly_q & enable;
    assign accent_now = (next_idx_q == 3'd0);

    // Bar position registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_dly_q <= 1'b0;
            beat_idx_q  <= 3'd0;
            next_idx_q  <= 3'd0;
            started_q   <= 1'b0;
            downbeat_q  <= 1'b0;
            led_q       <= 8'd0;
        end else begin
            pulse_dly_q <= pulse_dly_d;
            beat_idx_q  <= beat_idx_d;
            next_idx_q  <= next_idx_d;
            started_q   <= started_d;
            downbeat_q  <= downbeat_d;
            led_q       <= led_d;
        end
    end

    // Advance the bar on each beat; a restart request only redirects the following beat
    always_comb begin
        pulse_dly_d = pulse;
        beat_idx_d  = beat_idx_q;
        next_idx_d  = next_idx_q;
        started_d   = started_q;
        downbeat_d  = 1'b0;

        if (beat_evt) begin
            beat_idx_d = next_idx_q;
            started_d  = 1'b1;
            downbeat_d = accent_now;
            next_idx_d = wrap_next(next_idx_q, beats_per_bar);
        end

        if (enable && bar_restart) begin
            next_idx_d = 3'd0;
        end

        led_d = started_d ? (8'b1 << beat_idx_d) : 8'b0;
    end

    click_tone_gen #(
        .CLICK_LEN (CLICK_LEN),
        .ACC_HALF  (ACC_HALF),
        .NORM_HALF (NORM_HALF),
        .CW        (CW)
    ) u_click (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trigger      (beat_evt),
        .accent       (accent_now),
        .tone         (tone),
        .click_active (click_active)
    );

    assign beat_idx = beat_idx_q;
    assign downbeat = downbeat_q;
    assign led      = led_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - self-checking bench for beat_sequencer
module tb_beat_sequencer;
    import beat_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pulse;
    logic       enable;
    logic       bar_restart;
    logic [2:0] beats_per_bar;
    logic [2:0] beat_idx;
    logic       downbeat;
    logic [7:0] led;
    logic       click_active;
    logic       tone;

    beat_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pulse         (pulse),
        .enable        (enable),
        .bar_restart   (bar_restart),
        .beats_per_bar (beats_per_bar),
        .beat_idx      (beat_idx),
        .downbeat      (downbeat),
        .led           (led),
        .click_active  (click_active),
        .tone          (tone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] idx;
        logic       db;
        logic [7:0] led;
    } exp_t;

    typedef struct {
        logic [2:0] bpb;
        int         hold;
        bit         restart;
        logic [2:0] idx;
        logic       db;
        logic [7:0] led;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] bpb, input int hold, input bit restart,
                       input logic [2:0] idx, input logic db, input logic [7:0] l);
        vec_t v;
        v.bpb = bpb; v.hold = hold; v.restart = restart;
        v.idx = idx; v.db = db; v.led = l;
        vecs.push_back(v);
    endtask

    // Called at a negedge: fires one beat, then watches the click for `watch` cycles
    task automatic beat(input int hold, input int watch, input bit restart,
                        input logic [2:0] idx, input logic db, input logic [7:0] l);
        exp_t e;
        exp_t got;
        int   half;
        int   tone_err;
        int   act_cnt;
        int   db_cnt;
        logic exp_tone;
        e.idx = idx; e.db = db; e.led = l;
        sb.push_back(e);
        half = db ? DEF_ACC_HALF : DEF_NORM_HALF;
        tone_err = 0; act_cnt = 0; db_cnt = 0;
        pulse = 1'b1;
        bar_restart = restart;
        for (int k = 0; k < watch; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bar_restart = 1'b0;
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("beat_idx", 32'(beat_idx), 32'(got.idx));
                    check("downbeat", 32'(downbeat), 32'(got.db));
                    check("led", 32'(led), 32'(got.led));
                end
            end
            if (k == hold - 1) pulse = 1'b0;
            exp_tone = (k < DEF_CLICK_LEN) && (((k / half) % 2) == 0);
            if (tone !== exp_tone) tone_err++;
            if (click_active === 1'b1) act_cnt++;
            if (downbeat === 1'b1) db_cnt++;
        end
        check("tone_wave", 32'(tone_err), 32'd0);
        check("click_len", 32'(act_cnt), 32'((watch < DEF_CLICK_LEN) ? watch : DEF_CLICK_LEN));
        check("downbeat_cnt", 32'(db_cnt), 32'(db));
    endtask

    task automatic idle(input int n);
        int err;
        err = 0;
        repeat (n) begin
            @(negedge clk);
            if (click_active !== 1'b0 || tone !== 1'b0 || downbeat !== 1'b0) err++;
        end
        check("idle_quiet", 32'(err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dis_err;

        // bpb, hold, restart, idx, downbeat, led ; hold 0 = bar_restart only
        add(3'd4, 1, 0, 3'd0, 1, 8'h01);
        add(3'd4, 1, 0, 3'd1, 0, 8'h02);
        add(3'd4, 1, 0, 3'd2, 0, 8'h04);
        add(3'd4, 1, 0, 3'd3, 0, 8'h08);
        add(3'd4, 1, 0, 3'd0, 1, 8'h01);
        add(3'd4, 5, 0, 3'd1, 0, 8'h02);
        add(3'd4, 1, 0, 3'd2, 0, 8'h04);
        add(3'd4, 1, 0, 3'd3, 0, 8'h08);
        add(3'd0, 1, 0, 3'd0, 1, 8'h01);
        add(3'd0, 1, 0, 3'd1, 0, 8'h02);
        add(3'd0, 1, 0, 3'd2, 0, 8'h04);
        add(3'd0, 1, 0, 3'd3, 0, 8'h08);
        add(3'd0, 1, 0, 3'd4, 0, 8'h10);
        add(3'd0, 1, 0, 3'd5, 0, 8'h20);
        add(3'd0, 1, 0, 3'd6, 0, 8'h40);
        add(3'd0, 1, 0, 3'd7, 0, 8'h80);
        add(3'd0, 1, 0, 3'd0, 1, 8'h01);
        add(3'd0, 1, 0, 3'd1, 0, 8'h02);
        add(3'd0, 1, 0, 3'd2, 0, 8'h04);
        add(3'd0, 1, 0, 3'd3, 0, 8'h08);
        add(3'd0, 1, 0, 3'd4, 0, 8'h10);
        add(3'd3, 1, 0, 3'd5, 0, 8'h20);
        add(3'd3, 1, 0, 3'd0, 1, 8'h01);
        add(3'd3, 1, 0, 3'd1, 0, 8'h02);
        add(3'd4, 0, 0, 3'd1, 0, 8'h02);
        add(3'd4, 1, 0, 3'd0, 1, 8'h01);
        add(3'd4, 1, 0, 3'd1, 0, 8'h02);
        add(3'd4, 1, 1, 3'd2, 0, 8'h04);
        add(3'd4, 1, 0, 3'd0, 1, 8'h01);

        reset = 1'b1; pulse = 1'b0; enable = 1'b1; bar_restart = 1'b0; beats_per_bar = 3'd4;
        repeat (3) @(negedge clk);
        check("rst_beat_idx", 32'(beat_idx), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_downbeat", 32'(downbeat), 32'd0);
        check("rst_click_active", 32'(click_active), 32'd0);
        check("rst_tone", 32'(tone), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            beats_per_bar = vecs[i].bpb;
            if (vecs[i].hold == 0) begin
                bar_restart = 1'b1;
                @(negedge clk);
                bar_restart = 1'b0;
                @(negedge clk);
                check("restart_holds_idx", 32'(beat_idx), 32'(vecs[i].idx));
                check("restart_holds_led", 32'(led), 32'(vecs[i].led));
            end else begin
                beat(vecs[i].hold, 25, vecs[i].restart, vecs[i].idx, vecs[i].db, vecs[i].led);
                idle(25);
            end
        end

        // Retrigger: normal click cut after 10 cycles by an accented downbeat
        beat(1, 25, 0, 3'd1, 0, 8'h02);
        idle(25);
        beat(1, 25, 0, 3'd2, 0, 8'h04);
        idle(25);
        beat(1, 10, 0, 3'd3, 0, 8'h08);
        beat(1, 25, 0, 3'd0, 1, 8'h01);
        idle(25);

        // Enable dropped mid-click, pulses while disabled are ignored
        beat(1, 5, 0, 3'd1, 0, 8'h02);
        enable = 1'b0;
        @(negedge clk);
        check("mute_click_active", 32'(click_active), 32'd0);
        check("mute_tone", 32'(tone), 32'd0);
        dis_err = 0;
        repeat (3) begin
            pulse = 1'b1;
            repeat (2) @(negedge clk);
            pulse = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (click_active !== 1'b0 || tone !== 1'b0 || downbeat !== 1'b0) dis_err++;
            end
        end
        check("disabled_quiet", 32'(dis_err), 32'd0);
        check("disabled_beat_idx", 32'(beat_idx), 32'd1);
        check("disabled_led", 32'(led), 32'h02);
        enable = 1'b1;
        @(negedge clk);
        beat(1, 25, 0, 3'd2, 0, 8'h04);
        idle(5);

        // Async reset mid-click, checked between clock edges
        beat(1, 5, 0, 3'd3, 0, 8'h08);
        #2 reset = 1'b1;
        #1;
        check("areset_click_active", 32'(click_active), 32'd0);
        check("areset_tone", 32'(tone), 32'd0);
        check("areset_beat_idx", 32'(beat_idx), 32'd0);
        check("areset_led", 32'(led), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        beat(1, 25, 0, 3'd0, 1, 8'h01);
        idle(5);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
